// File: rtl/fp32_adder.sv
// fp32_adder: IEEE-754 binary32 adder, round-to-nearest-even, one-cycle registered result.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (clears s and out_valid)
//   in_valid  in   a/b valid this cycle
//   a, b      in   binary32 operands (caller flips b[31] to subtract)
//   s         out  registered sum, binary32
//   out_valid out  s holds a new result
module fp32_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        out_valid
);
    logic [7:0]  ea, eb, el, es, d, elm1;
    logic [23:0] ma, mb, ml, ms;
    logic        swap, sa, sb, sl, sub;
    logic [49:0] sh;
    logic [26:0] al, m;
    logic [27:0] sum;
    logic [4:0]  lz, shamt;
    logic [9:0]  e, ef;
    logic [24:0] mr;
    logic        rnd, nan_a, nan_b, inf_a, inf_b;
    logic [31:0] fin, res;

    // subnormals use effective exponent 1 with a zero hidden bit
    assign ea = a[30:23] == 8'd0 ? 8'd1 : a[30:23];
    assign eb = b[30:23] == 8'd0 ? 8'd1 : b[30:23];
    assign ma = {a[30:23] != 8'd0, a[22:0]};
    assign mb = {b[30:23] != 8'd0, b[22:0]};
    assign sa = a[31];
    assign sb = b[31];
    // magnitude order of binary32 equals the integer order of bits 30:0
    assign swap = b[30:0] > a[30:0];
    assign el = swap ? eb : ea;
    assign es = swap ? ea : eb;
    assign ml = swap ? mb : ma;
    assign ms = swap ? ma : mb;
    assign sl = swap ? sb : sa;
    assign sub = sa ^ sb;
    assign d = el - es;
    // aligned smaller operand: 24 mantissa bits + guard + round + sticky
    assign sh = {ms, 26'b0} >> d;
    assign al = d >= 8'd26 ? {26'b0, |ms} : {sh[49:24], |sh[23:0]};
    assign sum = sub ? {1'b0, ml, 3'b0} - {1'b0, al} : {1'b0, ml, 3'b0} + {1'b0, al};

    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
    end

    // left shift capped so the exponent never drops below 1 (gradual underflow)
    assign elm1 = el - 8'd1;
    assign shamt = ({3'b0, lz} < elm1) ? lz : elm1[4:0];
    assign m = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << shamt;
    assign e = sum[27] ? {2'b0, el} + 10'd1 : {2'b0, el} - {5'b0, shamt};
    assign rnd = m[2] & (m[1] | m[0] | m[3]);
    assign mr = {1'b0, m[26:3]} + {24'b0, rnd};
    // a missing hidden bit after rounding means a subnormal result (field 0)
    assign ef = mr[24] ? e + 10'd1 : (mr[23] ? e : 10'd0);
    assign fin = sum == '0 ? {sa & sb, 31'b0} :
                 ef >= 10'd255 ? {sl, 8'hFF, 23'b0} :
                 {sl, ef[7:0], mr[24] ? mr[23:1] : mr[22:0]};

    assign nan_a = a[30:23] == 8'hFF && a[22:0] != 23'd0;
    assign nan_b = b[30:23] == 8'hFF && b[22:0] != 23'd0;
    assign inf_a = a[30:23] == 8'hFF && a[22:0] == 23'd0;
    assign inf_b = b[30:23] == 8'hFF && b[22:0] == 23'd0;
    assign res = (nan_a || nan_b || (inf_a && inf_b && sub)) ? 32'h7FC00000 :
                 inf_a ? a : inf_b ? b : fin;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s         <= '0;
            out_valid <= 1'b0;
        end else begin
            s         <= res;
            out_valid <= in_valid;
        end
endmodule

// File: tb/tb_fp32_adder.sv
// tb_fp32_adder: vector table, reset/valid sequence and randomized check of fp32_adder.
// The reference model sums operands exactly as wide integers in units of 2^-149 and rounds once.
module tb_fp32_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] s;
    logic        out_valid;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;
    vec_t vecs[18];

    fp32_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .s(s), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 23'd0;
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 23'd0;
    endfunction

    // exact value of a finite binary32 in units of 2^-149
    function automatic logic signed [299:0] to_units(input logic [31:0] x);
        logic [299:0] mag;
        int sh;
        sh  = x[30:23] == 8'd0 ? 0 : int'(x[30:23]) - 1;
        mag = {276'b0, x[30:23] != 8'd0, x[22:0]} << sh;
        return x[31] ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic signed [299:0] n;
        logic [299:0] mag, rem, half, mm;
        logic sgn;
        int p, k;
        if (is_nan(x) || is_nan(y)) return 32'h7FC00000;
        if (is_inf(x) && is_inf(y)) return x[31] == y[31] ? x : 32'h7FC00000;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        n = to_units(x) + to_units(y);
        if (n == 0) return {x[31] & y[31], 31'b0};
        sgn = n < 0;
        mag = sgn ? 300'(-n) : 300'(n);
        p = 0;
        for (int i = 0; i < 300; i++)
            if (mag[i]) p = i;
        if (p <= 23) return {sgn, mag[30:0]};
        k = p - 23;
        mm = mag >> k;
        rem = mag & ((300'(1) << k) - 300'(1));
        half = 300'(1) << (k - 1);
        if (rem > half || (rem == half && mm[0])) mm = mm + 300'(1);
        if (mm == (300'(1) << 24)) begin
            mm = mm >> 1;
            k++;
        end
        if (k + 1 >= 255) return {sgn, 8'hFF, 23'b0};
        return {sgn, 8'(k + 1), mm[22:0]};
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b s=%08h, expected valid=%0b s=%08h",
                     name, got[32], got[31:0], want[32], want[31:0]);
        end
    endtask

    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic v);
        @(negedge clk);
        a = x;
        b = y;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r, x, y;
        logic [7:0]  ex;
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[3]  = '{32'h3F800001, 32'h33800000, 32'h3F800002};
        vecs[4]  = '{32'h3F800000, 32'h33800001, 32'h3F800001};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
        vecs[8]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000};
        vecs[9]  = '{32'h00000001, 32'h00000001, 32'h00000002};
        vecs[10] = '{32'h00800000, 32'h80000001, 32'h007FFFFF};
        vecs[11] = '{32'h007FFFFF, 32'h00000001, 32'h00800000};
        vecs[12] = '{32'h80000000, 32'h80000000, 32'h80000000};
        vecs[13] = '{32'h00000000, 32'h80000000, 32'h00000000};
        vecs[14] = '{32'h40400000, 32'h3F800000 ^ 32'h80000000, 32'h40000000};
        vecs[15] = '{32'h3F800000, 32'h3F800001 ^ 32'h80000000, 32'hB4000000};
        vecs[16] = '{32'hFF800000, 32'hFF800000, 32'hFF800000};
        vecs[17] = '{32'h3F800000, 32'h7F800000, 32'h7F800000};

        #3;
        check("reset_state", {out_valid, s}, {1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, 1'b1);
            check($sformatf("vec%0d_%08h_%08h", i, vecs[i].a, vecs[i].b),
                  {out_valid, s}, {1'b1, vecs[i].s});
        end

        apply(32'h3F800000, 32'h3F800000, 1'b1);
        check("pre_reset_load", {out_valid, s}, {1'b1, 32'h40000000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, s}, {1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("invalid_after_reset", {out_valid, s}, {1'b0, 32'h40000000});
        apply(32'h40400000, 32'h3F800000, 1'b0);
        check("s_updates_without_valid", {out_valid, s}, {1'b0, 32'h40800000});

        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            x = $urandom;
            y = $urandom;
            case (r[1:0])
                2'd0: ;
                2'd1: begin
                    ex = x[30:23] + 8'(r[4:2]) - 8'd3;
                    y[30:23] = ex;
                end
                2'd2: begin
                    x[30:23] = {6'b0, r[3:2]};
                    y[30:23] = {6'b0, r[5:4]};
                end
                default: begin
                    x[30:23] = 8'hFC + {6'b0, r[3:2]};
                    y[30:23] = 8'hFC + {6'b0, r[5:4]};
                end
            endcase
            if (r[6]) y[31] = ~y[31];
            apply(x, y, 1'b1);
            check($sformatf("rand%0d_%08h_%08h", i, x, y), {out_valid, s}, {1'b1, ref_add(x, y)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
Single-precision (IEEE-754 binary32) floating-point adder with a registered result. It computes s = a + b with full IEEE semantics. Subtraction is done by the caller, who flips bit 31 of b. The block sits in the arithmetic datapath and has a one-cycle latency with a simple valid pipeline flag.

Parameters:
none (format fixed to binary32: 1 sign bit, 8 exponent bits with bias 127, 23 fraction bits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  a/b are valid this cycle
a  input  32  operand A, binary32
b  input  32  operand B, binary32
s  output  32  registered sum, binary32
out_valid  output  1  s holds a new result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, s=32'h00000000 and out_valid=0, independent of clk. Reset asserted mid-operation discards the in-flight result.
- Latency: 1 cycle. At each rising clk, s <= round(a+b) and out_valid <= in_valid.
- s updates every cycle regardless of in_valid; out_valid qualifies it.
- No backpressure. A new operation is accepted every cycle.
- Datapath is fully combinational from a/b to the s register.
- Datapath steps:
  - unpack; hidden bit = 1 for normals, 0 for subnormals; subnormal effective exponent = 1;
  - swap so the larger magnitude is first (compare exponent, then mantissa);
  - align the smaller operand by right shift, keeping guard, round and sticky bits; shifts of 26 or more collapse into sticky;
  - add or subtract magnitudes per sign XOR;
  - normalise: 1-bit right shift on carry-out; leading-zero count then left shift on cancellation, with the left shift limited so the exponent does not drop below 1 (gradual underflow to subnormal);
  - round to nearest, ties to even; a rounding carry renormalises and increments the exponent.
- Result sign: sign of the larger-magnitude operand.
- Exact zero results:
  - x + (-x) gives +0 (32'h00000000);
  - (+0)+(+0) gives +0;
  - (-0)+(-0) gives -0 (32'h80000000);
  - (+0)+(-0) gives +0.
- Overflow: exponent reaching 255 after rounding gives signed infinity (7F800000 or FF800000).
- Special operands:
  - any NaN input gives canonical quiet NaN 7FC00000;
  - +inf + -inf gives 7FC00000;
  - inf + finite gives that inf;
  - inf + inf of the same sign gives that inf.
- Subnormal inputs and outputs are fully supported: no flush-to-zero.
- No exception flags are output.
- Results must match IEEE-754 RNE bit-exactly for all 2^64 input pairs.

Test Plan:
- Basic add and cancellation: 3F800000 + 3F800000 -> s=40000000 one cycle later with out_valid=1; 3F800000 + BF800000 -> 00000000.
- Rounding ties to even: 3F800000 + 33800000 -> 3F800000 (tie, stays even); 3F800001 + 33800000 -> 3F800002 (tie, rounds up to even); 3F800000 + 33800001 -> 3F800001.
- Overflow and specials:
  - 7F7FFFFF + 7F7FFFFF -> 7F800000;
  - 7F800000 + FF800000 -> 7FC00000;
  - 7FC00001 + 3F800000 -> 7FC00000;
  - FF800000 + 3F800000 -> FF800000.
- Subnormals and signed zero:
  - 00000001 + 00000001 -> 00000002;
  - 00800000 + 80000001 -> 007FFFFF;
  - 007FFFFF + 00000001 -> 00800000;
  - 80000000 + 80000000 -> 80000000.
- Subtraction via sign flip: a=40400000, b=3F800000^80000000 -> 40000000; a=3F800000, b=3F800001^80000000 -> B4000000.
- Reset and valid pipeline: drive in_valid=1 with operands, then pull rst_n low between edges -> s=00000000 and out_valid=0 immediately. Release rst_n; in_valid=0 at the next edge -> out_valid=0. Then a randomized run of 10,000 pairs (add and sub) against a reference model -> zero bit mismatches.
